// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
// The cnt width ITER_W is derived in the top via clog2(WIDTH+2).
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/booth_multiplier_seq_booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M,
// then an arithmetic right shift of {acc,mq,q_1}.
module booth_step
  import mult_pkg::*;
#(
  parameter int AW = 9,
  parameter int QW = 8
) (
  input  logic [AW-1:0] acc,
  input  logic [QW-1:0] mq,
  input  logic          q_1,
  input  logic [AW-1:0] m,
  output logic [AW-1:0] acc_n,
  output logic [QW-1:0] mq_n,
  output logic          q_1_n
);

  logic [AW-1:0] sum;

  always_comb begin
    sum = acc;
    case ({mq[0], q_1})
      BOOTH_ADD: sum = acc + m;
      BOOTH_SUB: sum = acc - m;
      default:   sum = acc;
    endcase
  end

  assign acc_n = {sum[AW-1], sum[AW-1:1]};
  assign mq_n  = {sum[0], mq[QW-1:1]};
  assign q_1_n = mq[0];

endmodule

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier, one iteration per clock.
// MULT_UNSIGNED_MODE_EN adds the sgn port (signed/unsigned select).
module booth_multiplier_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
`ifdef MULT_UNSIGNED_MODE_EN
  input  logic               sgn,
`endif
  input  logic               pause,
  output logic [2*WIDTH-1:0] Q,
  output logic               flag,
  input  logic               out_ready
);

`ifdef MULT_UNSIGNED_MODE_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif
  localparam int ITER_W = clog2(WIDTH + 2);

  state_t state, state_n;

  logic [EW:0]       m, acc, acc_n;
  logic [EW-1:0]     mq, mq_n;
  logic              q_1, q_1_n;
  logic [ITER_W-1:0] cnt;
  logic [EW-1:0]     a_x, b_x;
  logic [2*EW-1:0]   prod;
  logic              accept, step, last;

`ifdef MULT_UNSIGNED_MODE_EN
  assign a_x = {sgn & A[WIDTH-1], A};
  assign b_x = {sgn & B[WIDTH-1], B};
`else
  assign a_x = A;
  assign b_x = B;
`endif

  assign in_ready = (state == IDLE);
  assign flag     = (state == DONE);
  assign accept   = in_valid & in_ready;
  assign step     = (state == RUN) & ~pause;
  assign last     = step & (cnt == ITER_W'(1));
  assign prod     = {acc_n[EW-1:0], mq_n};

  booth_step #(
    .AW(EW + 1),
    .QW(EW)
  ) u_step (
    .acc  (acc),
    .mq   (mq),
    .q_1  (q_1),
    .m    (m),
    .acc_n(acc_n),
    .mq_n (mq_n),
    .q_1_n(q_1_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept)    state_n = RUN;
      RUN:     if (last)      state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m   <= '0;
      acc <= '0;
      mq  <= '0;
      q_1 <= 1'b0;
      cnt <= '0;
      Q   <= '0;
    end else if (accept) begin
      m   <= {a_x[EW-1], a_x};
      acc <= '0;
      mq  <= b_x;
      q_1 <= 1'b0;
      cnt <= ITER_W'(EW);
    end else if (step) begin
      acc <= acc_n;
      mq  <= mq_n;
      q_1 <= q_1_n;
      cnt <= cnt - 1'b1;
      // Product is taken from the post-shift values of the final step.
      if (last) Q <= prod[2*WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Self-checking bench for booth_multiplier_seq (WIDTH=8 and WIDTH=16).
// Reference: plain multiplication plus a latency/handshake model.
module tb_booth_multiplier_seq;

`ifdef MULT_UNSIGNED_MODE_EN
  localparam int LAT   = 9;
  localparam int LAT16 = 17;
`else
  localparam int LAT   = 8;
  localparam int LAT16 = 16;
`endif

  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [7:0]  a = 0, b = 0;
  logic        sgn = 1;
  logic        pause = 0;
  logic [15:0] q;
  logic        flag;
  logic        out_ready = 1;

  logic        in_valid16 = 0;
  logic        in_ready16;
  logic [15:0] a16 = 0, b16 = 0;
  logic [31:0] q16;
  logic        flag16;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  booth_multiplier_seq #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a),
    .B        (b),
`ifdef MULT_UNSIGNED_MODE_EN
    .sgn      (sgn),
`endif
    .pause    (pause),
    .Q        (q),
    .flag     (flag),
    .out_ready(out_ready)
  );

  booth_multiplier_seq #(.WIDTH(16)) dut16 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid16),
    .in_ready (in_ready16),
    .A        (a16),
    .B        (b16),
`ifdef MULT_UNSIGNED_MODE_EN
    .sgn      (sgn),
`endif
    .pause    (1'b0),
    .Q        (q16),
    .flag     (flag16),
    .out_ready(1'b1)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] x,
                                          input logic [7:0] y,
                                          input logic s);
    logic [15:0] xe, ye;
    xe = s ? {{8{x[7]}}, x} : {8'h00, x};
    ye = s ? {{8{y[7]}}, y} : {8'h00, y};
    return xe * ye;
  endfunction

  // Model: 0 idle, 1 busy, 2 holding result
  int          m_ph;
  int          m_left;
  logic [15:0] m_q, m_pend;
  logic        s_eff;

`ifdef MULT_UNSIGNED_MODE_EN
  assign s_eff = sgn;
`else
  assign s_eff = 1'b1;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph   <= 0;
      m_left <= 0;
      m_q    <= '0;
      m_pend <= '0;
    end else begin
      case (m_ph)
        0: if (in_valid) begin
          m_ph   <= 1;
          m_left <= LAT;
          m_pend <= ref_mul(a, b, s_eff);
        end
        1: if (!pause) begin
          if (m_left == 1) begin
            m_ph <= 2;
            m_q  <= m_pend;
          end else begin
            m_left <= m_left - 1;
          end
        end
        default: if (out_ready) m_ph <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_flag", 64'(flag), 64'(m_ph == 2));
      chk("model_ready", 64'(in_ready), 64'(m_ph == 0));
      chk("model_q", 64'(q), 64'(m_q));
    end
  end

  task automatic run_op(input string nm, input logic [7:0] x,
                        input logic [7:0] y, input logic [15:0] exp,
                        input int pz, input int hold);
    int k;
    @(negedge clk);
    #2;
    chk({nm, "_ready"}, 64'(in_ready), 64'd1);
    a = x;
    b = y;
    in_valid = 1;
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    #2;
    in_valid = (hold > 0);
    a = 8'($urandom);
    b = 8'($urandom);
    k = 0;
    while (!flag && k < 100) begin
      pause = (k >= 2 && k < 2 + pz);
      @(posedge clk);
      k++;
      @(negedge clk);
      #2;
    end
    pause = 0;
    chk({nm, "_lat"}, 64'(k), 64'(LAT + pz));
    chk({nm, "_q"}, 64'(q), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      #2;
      chk({nm, "_hold_flag"}, 64'(flag), 64'd1);
      chk({nm, "_hold_q"}, 64'(q), 64'(exp));
      chk({nm, "_hold_rdy"}, 64'(in_ready), 64'd0);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    #2;
    chk({nm, "_handoff"}, 64'({in_ready, flag}), 64'b10);
    chk({nm, "_qkeep"}, 64'(q), 64'(exp));
  endtask

  initial begin
    int k;
    #1;
    chk("rst_q", 64'(q), 64'd0);
    chk("rst_flag", 64'(flag), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    #3 rst = 0;

    // Pin the reference model itself
    chk("ref_m7m7", 64'(ref_mul(8'hF9, 8'hF9, 1'b1)), 64'h0031);
    chk("ref_80x7f", 64'(ref_mul(8'h80, 8'h7F, 1'b1)), 64'hC080);
    chk("ref_u_f9", 64'(ref_mul(8'hF9, 8'hF9, 1'b0)), 64'hF231);

    run_op("m7m7", 8'hF9, 8'hF9, 16'h0031, 0, 0);
    run_op("10m7", 8'h0A, 8'hF9, 16'hFFBA, 0, 0);
    run_op("7f7f", 8'h7F, 8'h7F, 16'h3F01, 0, 0);
    run_op("8080", 8'h80, 8'h80, 16'h4000, 0, 0);
    run_op("807f", 8'h80, 8'h7F, 16'hC080, 0, 0);
    run_op("zero", 8'h00, 8'hF9, 16'h0000, 0, 0);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #2 pause = ~pause;
    end
    @(negedge clk);
    #2 pause = 0;
    chk("idle_pause_rdy", 64'(in_ready), 64'd1);

    run_op("pause3", 8'hF9, 8'hF9, 16'h0031, 3, 0);
    run_op("hold5", 8'hF9, 8'hF9, 16'h0031, 0, 5);

    // Abort mid-RUN
    @(negedge clk);
    #2;
    a = 8'h7F;
    b = 8'h7F;
    in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    #2 in_valid = 0;
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("abort_flag", 64'(flag), 64'd0);
    chk("abort_q", 64'(q), 64'd0);
    chk("abort_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    #3 rst = 0;
    run_op("after_rst", 8'h0A, 8'hF9, 16'hFFBA, 0, 0);

`ifdef MULT_UNSIGNED_MODE_EN
    sgn = 0;
    run_op("u_f9f9", 8'hF9, 8'hF9, 16'hF231, 0, 0);
    sgn = 1;
    run_op("s_f9f9", 8'hF9, 8'hF9, 16'h0031, 0, 0);
`endif

    @(negedge clk);
    #2;
    a16 = 16'h8000;
    b16 = 16'h8000;
    in_valid16 = 1;
    @(posedge clk);
    @(negedge clk);
    #2 in_valid16 = 0;
    k = 0;
    while (!flag16 && k < 100) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      #2;
    end
    chk("w16_lat", 64'(k), 64'(LAT16));
    chk("w16_q", 64'(q16), 64'h40000000);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
